// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement trace buffer: captures retired instructions into a FWFT FIFO,
// either continuously (stream) or as a one-shot window starting at a trigger PC.
module rvfi_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rvfi_valid,
  input  logic [31:0]                rvfi_pc_rdata,
  input  logic [31:0]                rvfi_insn,
  input  logic [31:0]                rvfi_rd_wdata,
  input  logic [31:0]                rvfi_mem_addr,
  input  logic [4:0]                 rvfi_rd_addr,
  input  logic                       cfg_enable,
  input  logic                       cfg_mode,
  input  logic [31:0]                cfg_trig_pc,
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic [CNT_W-1:0]           trc_seq,
  output logic [31:0]                trc_pc,
  output logic [31:0]                trc_insn,
  output logic [31:0]                trc_rd_wdata,
  output logic [31:0]                trc_mem_addr,
  output logic [4:0]                 trc_rd_addr,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [1:0]                 state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] seq;
    logic [31:0]      pc;
    logic [31:0]      insn;
    logic [31:0]      rd_wdata;
    logic [31:0]      mem_addr;
    logic [4:0]       rd_addr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic   trig_hit, capture, pop, full, push, drop;
  entry_t wr_entry, shown;

  always_comb begin
    trig_hit = rvfi_valid && (rvfi_pc_rdata == cfg_trig_pc);
    capture  = cfg_enable && (((state_q == S_CAPTURE) && rvfi_valid) ||
                              ((state_q == S_ARMED) && trig_hit));
    pop      = (level_q != '0) && trc_ready;
    full     = (level_q == LVL_W'(DEPTH));
    // A pop in the same cycle frees the slot the push needs.
    push     = capture && (!full || pop);
    drop     = capture && full && !pop;

    wr_entry          = '0;
    wr_entry.seq      = seq_q;
    wr_entry.pc       = rvfi_pc_rdata;
    wr_entry.insn     = rvfi_insn;
    wr_entry.rd_wdata = rvfi_rd_wdata;
    wr_entry.mem_addr = rvfi_mem_addr;
    wr_entry.rd_addr  = rvfi_rd_addr;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    drop_d   = (drop && (drop_q != '1)) ? drop_q + CNT_W'(1) : drop_q;

    state_d = state_q;
    mode_d  = mode_q;
    seq_d   = capture ? seq_q + CNT_W'(1) : seq_q;
    taken_d = capture ? taken_q + LVL_W'(1) : taken_q;

    if (!cfg_enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          mode_d  = cfg_mode;
          state_d = cfg_mode ? S_ARMED : S_CAPTURE;
          seq_d   = '0;
          taken_d = '0;
        end
        S_ARMED:   if (trig_hit) state_d = S_CAPTURE;
        // The trigger already counted as the first of the DEPTH captures.
        S_CAPTURE: if (mode_q && capture && (taken_q == LVL_W'(DEPTH - 1))) state_d = S_DONE;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      taken_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      taken_q  <= taken_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Payload reads as zero whenever nothing is buffered, including after reset.
  always_comb begin
    shown        = trc_valid ? mem_q[rd_ptr_q] : '0;
    trc_seq      = shown.seq;
    trc_pc       = shown.pc;
    trc_insn     = shown.insn;
    trc_rd_wdata = shown.rd_wdata;
    trc_mem_addr = shown.mem_addr;
    trc_rd_addr  = shown.rd_addr;
  end

  assign trc_valid = (level_q != '0);
  assign level     = level_q;
  assign drop_cnt  = drop_q;
  assign state     = state_q;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Bench for rvfi_trace_buffer (DEPTH=4): queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_rvfi_trace_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rvfi_valid;
  logic [31:0] rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata, rvfi_mem_addr;
  logic [4:0]  rvfi_rd_addr;
  logic        cfg_enable, cfg_mode;
  logic [31:0] cfg_trig_pc;
  logic        trc_valid, trc_ready;
  logic [CNT_W-1:0] trc_seq;
  logic [31:0] trc_pc, trc_insn, trc_rd_wdata, trc_mem_addr;
  logic [4:0]  trc_rd_addr;
  logic [2:0]  level;
  logic [CNT_W-1:0] drop_cnt;
  logic [1:0]  state;

  rvfi_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .rvfi_valid(rvfi_valid),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_rd_addr(rvfi_rd_addr), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_trig_pc(cfg_trig_pc), .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_seq(trc_seq), .trc_pc(trc_pc), .trc_insn(trc_insn),
    .trc_rd_wdata(trc_rd_wdata), .trc_mem_addr(trc_mem_addr),
    .trc_rd_addr(trc_rd_addr), .level(level), .drop_cnt(drop_cnt), .state(state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of entries plus the capture session rules
  typedef struct {
    logic [CNT_W-1:0] seq;
    logic [31:0] pc, insn, wd, ma;
    logic [4:0]  rd;
  } ent_t;

  ent_t mq[$];
  int   m_state = 0;
  int   m_seq   = 0;
  int   m_drop  = 0;
  int   m_taken = 0;
  bit   m_mode  = 1'b0;

  always @(posedge clk) begin : model
    bit   pop, cap;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_state = 0; m_seq = 0; m_drop = 0; m_taken = 0; m_mode = 1'b0;
    end else begin
      pop = (mq.size() != 0) && trc_ready;
      cap = 1'b0;
      if (!cfg_enable) m_state = 0;
      else begin
        case (m_state)
          0: begin m_mode = cfg_mode; m_state = cfg_mode ? 1 : 2; m_seq = 0; m_taken = 0; end
          1: if (rvfi_valid && rvfi_pc_rdata == cfg_trig_pc) begin cap = 1'b1; m_state = 2; end
          2: cap = rvfi_valid;
          default: ;
        endcase
      end
      if (pop) void'(mq.pop_front());
      if (cap) begin
        e.seq = m_seq[CNT_W-1:0]; e.pc = rvfi_pc_rdata; e.insn = rvfi_insn;
        e.wd = rvfi_rd_wdata; e.ma = rvfi_mem_addr; e.rd = rvfi_rd_addr;
        if (mq.size() < DEPTH) mq.push_back(e);
        else if (m_drop < 65535) m_drop++;
        m_seq = (m_seq + 1) % 65536;
        m_taken++;
        if (m_mode && m_taken == DEPTH) m_state = 3;
      end
    end
  end

  // Scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("level", 64'(level), 64'(mq.size()));
      chk("trc_valid", 64'(trc_valid), 64'(mq.size() != 0));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("state", 64'(state), 64'(m_state));
      if (mq.size() != 0) begin
        chk("trc_seq", 64'(trc_seq), 64'(mq[0].seq));
        chk("trc_pc", 64'(trc_pc), 64'(mq[0].pc));
        chk("trc_insn", 64'(trc_insn), 64'(mq[0].insn));
        chk("trc_rd_wdata", 64'(trc_rd_wdata), 64'(mq[0].wd));
        chk("trc_mem_addr", 64'(trc_mem_addr), 64'(mq[0].ma));
        chk("trc_rd_addr", 64'(trc_rd_addr), 64'(mq[0].rd));
      end
    end
  end

  // Driver: hold inputs across one rising edge, return just after it
  task automatic step(input bit v, input logic [31:0] pc, input bit rdy);
    rvfi_valid    = v;
    rvfi_pc_rdata = pc;
    rvfi_insn     = pc ^ 32'h0000_0013;
    rvfi_rd_wdata = pc + 32'd1;
    rvfi_mem_addr = {pc[29:0], 2'b00};
    rvfi_rd_addr  = pc[6:2];
    trc_ready     = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int nexp;
    reset = 1'b1; cfg_enable = 1'b0; cfg_mode = 1'b0; cfg_trig_pc = 32'h0;
    step(0, 0, 0);
    cmp_on = 1'b1;
    step(0, 0, 0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(trc_valid), 64'd0);
    chk("rst_payload", 64'(trc_pc), 64'd0);
    reset = 1'b0;

    // Stream mode, no drain: overflow and seq continuity
    cfg_enable = 1'b1; cfg_mode = 1'b0;
    step(0, 0, 0);
    chk("stream_state", 64'(state), 64'd2);
    for (int i = 0; i < 6; i++) step(1, 32'h100 + 32'(4 * i), 0);
    chk("ovf_level", 64'(level), 64'd4);
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_seq", 64'(trc_seq), 64'(i));
      step(0, 0, 1);
    end
    chk("ovf_empty", 64'(level), 64'd0);
    step(1, 32'h200, 0);
    chk("next_seq", 64'(trc_seq), 64'd6);
    step(0, 0, 1);

    // Full buffer with simultaneous pop and push
    for (int i = 0; i < 4; i++) step(1, 32'h280 + 32'(4 * i), 0);
    chk("full_level", 64'(level), 64'd4);
    step(1, 32'h300, 1);
    chk("fullpp_level", 64'(level), 64'd4);
    chk("fullpp_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 4; i++) begin
      chk("fullpp_seq", 64'(trc_seq), 64'(8 + i));
      if (i == 3) chk("fullpp_tail_pc", 64'(trc_pc), 64'h300);
      step(0, 0, 1);
    end

    // Triggered one-shot
    reset = 1'b1; cfg_enable = 1'b0;
    step(0, 0, 0);
    reset = 1'b0;
    cfg_enable = 1'b1; cfg_mode = 1'b1; cfg_trig_pc = 32'h80;
    step(0, 0, 0);
    chk("armed", 64'(state), 64'd1);
    step(1, 32'h70, 0);
    step(1, 32'h74, 0);
    chk("armed_ignore", 64'(level), 64'd0);
    for (int i = 0; i < 4; i++) step(1, 32'h80 + 32'(4 * i), 0);
    chk("oneshot_done", 64'(state), 64'd3);
    step(1, 32'h90, 0);
    chk("done_level", 64'(level), 64'd4);
    chk("done_drop", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("oneshot_pc", 64'(trc_pc), 64'(32'h80 + 32'(4 * i)));
      chk("oneshot_seq", 64'(trc_seq), 64'(i));
      step(0, 0, 1);
    end

    // Disable with entries buffered while retirements keep coming
    cfg_enable = 1'b0;
    step(0, 0, 0);
    cfg_enable = 1'b1; cfg_mode = 1'b0;
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h400 + 32'(4 * i), 0);
    cfg_enable = 1'b0;
    step(1, 32'h500, 0);
    chk("dis_state", 64'(state), 64'd0);
    chk("dis_level", 64'(level), 64'd3);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (trc_valid) n++;
      step(1, 32'h504 + 32'(4 * i), 1);
    end
    chk("dis_drained", 64'(n), 64'd3);
    chk("dis_empty", 64'(level), 64'd0);

    // Reset mid-drain
    cfg_enable = 1'b1;
    step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 32'h600 + 32'(4 * i), 0);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("pre_rst_level", 64'(level), 64'd2);
    chk("pre_rst_drop", 64'(drop_cnt), 64'd2);
    reset = 1'b1;
    step(1, 32'h700, 1);
    chk("mid_rst_valid", 64'(trc_valid), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    chk("mid_rst_state", 64'(state), 64'd0);
    chk("mid_rst_seq", 64'(trc_seq), 64'd0);
    reset = 1'b0;

    // Full-rate push and pop across several pointer wraps
    step(0, 0, 0);
    nexp = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (trc_valid) begin
        chk("rate_seq", 64'(trc_seq), 64'(nexp));
        nexp++;
      end
      step(1, 32'h800 + 32'(4 * i), 1);
    end
    chk("rate_count", 64'(nexp), 64'd11);
    chk("rate_last", 64'(trc_seq), 64'd11);
    chk("rate_drop", 64'(drop_cnt), 64'd0);
    step(0, 0, 1);
    chk("rate_empty", 64'(level), 64'd0);

    step(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
